// File: rtl/iir_biquad_cascade.sv
// Cascade of SECTIONS Direct-Form-I biquads sharing one signed MAC, 6 cycles per section.
// Latency 6*SECTIONS cycles from accept to valid; en while busy is dropped and flagged on overrun.
module iir_biquad_cascade #(
    parameter int N        = 16,
    parameter int FRAC     = 14,
    parameter int SECTIONS = 2,
    parameter int ACC_W    = 2*N+3
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        en,
    input  logic [N-1:0]                                X,
    input  logic                                        clear_state,
    input  logic                                        cfg_we,
    input  logic [((SECTIONS > 1) ? $clog2(SECTIONS) : 1)-1:0] cfg_sec,
    input  logic [2:0]                                  cfg_idx,
    input  logic [N-1:0]                                cfg_data,
    output logic                                        busy,
    output logic                                        valid,
    output logic [N-1:0]                                Y,
    output logic                                        sat,
    output logic                                        overrun
);

    localparam int SW = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
    localparam logic signed [ACC_W-1:0] HALF = {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
    localparam logic signed [N-1:0]     ONE  = {{(N-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB} state_t;

    state_t                  state;
    logic [2:0]              tap;
    logic [SW-1:0]           sec;
    logic signed [N-1:0]     xin;
    logic signed [ACC_W-1:0] acc;
    logic                    sat_acc;

    logic signed [N-1:0] coef [SECTIONS][5];
    logic signed [N-1:0] x1 [SECTIONS];
    logic signed [N-1:0] x2 [SECTIONS];
    logic signed [N-1:0] y1 [SECTIONS];
    logic signed [N-1:0] y2 [SECTIONS];

    logic signed [N-1:0]     c_sel;
    logic signed [N-1:0]     d_sel;
    logic signed [2*N-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] shr;
    logic signed [N-1:0]     r;
    logic                    r_sat;

    assign busy = (state != S_IDLE);

    // Tap order: a0*x, a1*x1, a2*x2, b1*y1, b2*y2 (b taps are subtracted).
    always_comb begin
        c_sel = coef[sec][0];
        d_sel = xin;
        case (tap)
            3'd1: begin c_sel = coef[sec][1]; d_sel = x1[sec]; end
            3'd2: begin c_sel = coef[sec][2]; d_sel = x2[sec]; end
            3'd3: begin c_sel = coef[sec][3]; d_sel = y1[sec]; end
            3'd4: begin c_sel = coef[sec][4]; d_sel = y2[sec]; end
            default: ;
        endcase
    end

    assign prod     = c_sel * d_sel;
    assign prod_ext = {{(ACC_W-2*N){prod[2*N-1]}}, prod};
    assign rnd      = acc + HALF;
    assign shr      = rnd >>> FRAC;

    always_comb begin
        r     = shr[N-1:0];
        r_sat = 1'b0;
        if (shr > MAXV) begin
            r     = MAXV[N-1:0];
            r_sat = 1'b1;
        end else if (shr < MINV) begin
            r     = MINV[N-1:0];
            r_sat = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            tap     <= '0;
            sec     <= '0;
            xin     <= '0;
            acc     <= '0;
            sat_acc <= 1'b0;
            Y       <= '0;
            valid   <= 1'b0;
            sat     <= 1'b0;
            overrun <= 1'b0;
            for (int s = 0; s < SECTIONS; s++) begin
                x1[s]      <= '0;
                x2[s]      <= '0;
                y1[s]      <= '0;
                y2[s]      <= '0;
                coef[s][0] <= ONE;
                coef[s][1] <= '0;
                coef[s][2] <= '0;
                coef[s][3] <= '0;
                coef[s][4] <= '0;
            end
        end else begin
            valid   <= 1'b0;
            overrun <= en && (state != S_IDLE);

            // Coefficients only change between samples, so a sample never sees a mix.
            if (state == S_IDLE && cfg_we && int'(cfg_sec) < SECTIONS && cfg_idx < 3'd5)
                coef[cfg_sec][cfg_idx] <= cfg_data;

            case (state)
                S_IDLE: begin
                    if (clear_state) begin
                        for (int s = 0; s < SECTIONS; s++) begin
                            x1[s] <= '0;
                            x2[s] <= '0;
                            y1[s] <= '0;
                            y2[s] <= '0;
                        end
                    end
                    if (en) begin
                        xin     <= X;
                        acc     <= '0;
                        tap     <= '0;
                        sec     <= '0;
                        sat_acc <= 1'b0;
                        sat     <= 1'b0;
                        state   <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= (tap >= 3'd3) ? acc - prod_ext : acc + prod_ext;
                    if (tap == 3'd4)
                        state <= S_WB;
                    else
                        tap <= tap + 3'd1;
                end
                S_WB: begin
                    x2[sec] <= x1[sec];
                    x1[sec] <= xin;
                    y2[sec] <= y1[sec];
                    y1[sec] <= r;
                    if (int'(sec) < SECTIONS - 1) begin
                        sec     <= sec + SW'(1);
                        xin     <= r;
                        acc     <= '0;
                        tap     <= '0;
                        sat_acc <= sat_acc | r_sat;
                        state   <= S_MAC;
                    end else begin
                        Y     <= r;
                        sat   <= sat_acc | r_sat;
                        valid <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Directed and randomized checks of iir_biquad_cascade against a plain-arithmetic cascade model.
module tb_iir_biquad_cascade;

    localparam int N    = 16;
    localparam int FRAC = 14;
    localparam int SECT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [N-1:0]  X;
    logic          clear_state;
    logic          cfg_we;
    logic [0:0]    cfg_sec;
    logic [2:0]    cfg_idx;
    logic [N-1:0]  cfg_data;
    logic          busy;
    logic          valid;
    logic [N-1:0]  Y;
    logic          sat;
    logic          overrun;

    int total = 0;
    int bad   = 0;

    longint mc  [SECT][5];
    longint mx1 [SECT];
    longint mx2 [SECT];
    longint my1 [SECT];
    longint my2 [SECT];
    longint exp_y;
    bit     exp_s;

    iir_biquad_cascade #(.N(N), .FRAC(FRAC), .SECTIONS(SECT)) dut (
        .clk(clk), .rst(rst), .en(en), .X(X), .clear_state(clear_state),
        .cfg_we(cfg_we), .cfg_sec(cfg_sec), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .busy(busy), .valid(valid), .Y(Y), .sat(sat), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: spec-level arithmetic on a whole sample at once.
    task automatic m_reset();
        for (int k = 0; k < SECT; k++) begin
            mc[k][0] = 64'sd16384;
            for (int i = 1; i < 5; i++) mc[k][i] = 0;
            mx1[k] = 0; mx2[k] = 0; my1[k] = 0; my2[k] = 0;
        end
    endtask

    task automatic m_clear();
        for (int k = 0; k < SECT; k++) begin
            mx1[k] = 0; mx2[k] = 0; my1[k] = 0; my2[k] = 0;
        end
    endtask

    task automatic m_cfg(input int s, input int i, input longint d);
        if (s < SECT && i < 5) mc[s][i] = d;
    endtask

    task automatic m_step(input longint xin);
        longint x, acc, r;
        x = xin;
        exp_s = 1'b0;
        for (int k = 0; k < SECT; k++) begin
            acc = mc[k][0]*x + mc[k][1]*mx1[k] + mc[k][2]*mx2[k] - mc[k][3]*my1[k] - mc[k][4]*my2[k];
            r = (acc + (longint'(1) << (FRAC-1))) >>> FRAC;
            if (r > 32767) begin r = 32767; exp_s = 1'b1; end
            else if (r < -32768) begin r = -32768; exp_s = 1'b1; end
            mx2[k] = mx1[k]; mx1[k] = x; my2[k] = my1[k]; my1[k] = r;
            x = r;
        end
        exp_y = x;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_reset();
    endtask

    task automatic cfgw(input int s, input int i, input longint d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_sec = 1'(s); cfg_idx = 3'(i); cfg_data = N'(d);
        @(posedge clk);
        #1 cfg_we = 1'b0;
        m_cfg(s, i, d);
    endtask

    task automatic clr();
        @(negedge clk);
        clear_state = 1'b1;
        @(posedge clk);
        #1 clear_state = 1'b0;
        m_clear();
    endtask

    // Accept one sample, optionally with clear and/or a coefficient write in the same cycle.
    task automatic send(input longint x, input bit c, input bit we, input int s, input int i, input longint d);
        @(negedge clk);
        en = 1'b1; X = N'(x); clear_state = c;
        cfg_we = we; cfg_sec = 1'(s); cfg_idx = 3'(i); cfg_data = N'(d);
        @(posedge clk);
        #1;
        en = 1'b0; clear_state = 1'b0; cfg_we = 1'b0;
        if (we) m_cfg(s, i, d);
        if (c) m_clear();
        m_step(x);
    endtask

    task automatic wait_valid(input string tag, input int start);
        int cyc;
        bit got;
        cyc = start;
        got = 1'b0;
        while (cyc < 40 && !got) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) chk({tag, "_busy"}, longint'(busy), 1);
            if (valid) got = 1'b1;
        end
        chk({tag, "_lat"}, got ? longint'(cyc) : -1, 12);
        chk({tag, "_y"}, longint'($signed(Y)), exp_y);
        chk({tag, "_sat"}, longint'(sat), longint'(exp_s));
    endtask

    task automatic run(input string tag, input longint x);
        send(x, 1'b0, 1'b0, 0, 0, 0);
        wait_valid(tag, 0);
    endtask

    initial begin
        int    nvalid;
        int    s, i;
        bit    c, we;
        longint d;
        logic [15:0] r16;

        rst = 1'b1; en = 1'b0; X = '0; clear_state = 1'b0;
        cfg_we = 1'b0; cfg_sec = '0; cfg_idx = '0; cfg_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        m_reset();

        chk("rst_busy", longint'(busy), 0);
        chk("rst_valid", longint'(valid), 0);
        chk("rst_y", longint'($signed(Y)), 0);
        chk("rst_sat", longint'(sat), 0);
        chk("rst_ovr", longint'(overrun), 0);

        run("pass_1000", 1000);
        chk("pass_1000_abs", longint'($signed(Y)), 1000);
        run("pass_min", -32768);
        chk("pass_min_abs", longint'($signed(Y)), -32768);

        // FIR averaging on section 0
        cfgw(0, 0, 4096); cfgw(0, 1, 4096); cfgw(0, 2, 4096);
        clr();
        run("fir0", 4000);
        chk("fir0_abs", longint'($signed(Y)), 1000);
        run("fir1", 0);
        run("fir2", 0);
        run("fir3", 0);
        chk("fir3_abs", longint'($signed(Y)), 0);

        // clear_state after an impulse leaves nothing to ring out
        run("clr_imp", 4000);
        clr();
        run("clr_zero", 0);
        chk("clr_zero_abs", longint'($signed(Y)), 0);

        // First-order feedback decay, rounding half up at 62.5
        do_reset();
        cfgw(0, 0, 16384); cfgw(0, 3, -8192);
        clr();
        run("fb0", 1000);
        for (int k = 1; k < 5; k++) run($sformatf("fb%0d", k), 0);
        chk("fb4_abs", longint'($signed(Y)), 63);

        // Saturation in both sections
        do_reset();
        cfgw(0, 0, 32767); cfgw(1, 0, 32767);
        run("sat_pos", 30000);
        chk("sat_pos_abs", longint'($signed(Y)), 32767);
        run("sat_neg", -30000);
        chk("sat_neg_abs", longint'($signed(Y)), -32768);
        run("sat_small", 100);

        // en and a cfg write while busy are both dropped
        do_reset();
        send(777, 1'b0, 1'b0, 0, 0, 0);
        repeat (3) @(negedge clk);
        en = 1'b1; X = 16'd5; cfg_we = 1'b1; cfg_sec = 1'b0; cfg_idx = 3'd0; cfg_data = '0;
        @(posedge clk);
        #1;
        en = 1'b0; cfg_we = 1'b0;
        chk("hs_overrun", longint'(overrun), 1);
        wait_valid("hs", 3);
        chk("hs_ovr_clr", longint'(overrun), 0);
        run("hs_after", -4321);
        chk("hs_after_abs", longint'($signed(Y)), -4321);

        // Reset in the middle of a sample
        cfgw(1, 0, 8192);
        send(1234, 1'b0, 1'b0, 0, 0, 0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m_reset();
        chk("mid_busy", longint'(busy), 0);
        chk("mid_valid", longint'(valid), 0);
        nvalid = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (valid) nvalid++;
        end
        chk("mid_novalid", longint'(nvalid), 0);
        run("mid_pass", 2222);

        // Clear coinciding with accept uses zeroed state
        cfgw(0, 3, -12000);
        run("ce_a", 9000);
        send(0, 1'b1, 1'b0, 0, 0, 0);
        wait_valid("ce_b", 0);
        chk("ce_b_abs", longint'($signed(Y)), 0);

        // Random samples with random same-cycle coefficient writes and clears
        for (int n = 0; n < 40; n++) begin
            c  = ($urandom_range(3) == 0);
            we = ($urandom_range(2) == 0);
            s  = int'($urandom_range(1));
            i  = int'($urandom_range(7));
            r16 = 16'($urandom);
            d  = longint'($signed(r16)) / 2;
            r16 = 16'($urandom);
            send(longint'($signed(r16)), c, we, s, i, d);
            wait_valid($sformatf("rnd%0d", n), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iir_biquad_cascade.md
Name: iir_biquad_cascade

Overview:
- Parametrised cascade of SECTIONS Direct-Form-I biquad IIR sections for the sonar receive chain, the successor to the single-section IIR stage.
- One signed multiply-accumulate unit is time-multiplexed across all taps and sections.
- Per-section coefficients are held in a run-time writable register file.
- Output is rounded and saturated back to N bits, so cascades never grow in width.

Parameters:
- N, 16, data and coefficient width (signed two's complement).
- FRAC, 14, coefficient fractional bits (Q(N-FRAC).FRAC; 1.0 = 2^FRAC).
- SECTIONS, 2, number of cascaded biquads (1..8).
- ACC_W, 2*N+3, accumulator width; guarantees no overflow for 5 products.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  input sample strobe; X is sampled when en=1 and busy=0.
- X  in  N  signed input sample.
- clear_state  in  1  when idle, zeroes all delay lines (x1,x2,y1,y2) of every section next edge; ignored while busy.
- cfg_we  in  1  coefficient write strobe.
- cfg_sec  in  max(1,$clog2(SECTIONS))  target section.
- cfg_idx  in  3  0=a0, 1=a1, 2=a2, 3=b1, 4=b2; 5..7 ignored.
- cfg_data  in  N  signed coefficient value.
- busy  out  1  high from the cycle after sample accept until valid.
- valid  out  1  one-cycle pulse with Y.
- Y  out  N  signed, rounded, saturated cascade output; held until the next valid.
- sat  out  1  high with valid if any section saturated for this sample.
- overrun  out  1  one-cycle pulse when en=1 arrives while busy=1.

Behaviour:
- Per section k: acc = a0*x + a1*x1 + a2*x2 - b1*y1 - b2*y2. Both b terms are subtracted; signed products are sign-extended to ACC_W.
- Section output: r = (acc + 2^(FRAC-1)) >>> FRAC (round half up), then saturate to [-2^(N-1), 2^(N-1)-1]. r feeds section k+1 as x.
- WB updates: x2<=x1, x1<=x, y2<=y1, y1<=r. y1 stores the saturated value.
- FSM states:
  - IDLE: en=1 captures X, zeroes the accumulator, tap=0, sec=0, goes to MAC.
  - MAC: accumulates one tap per cycle for 5 cycles (tap 0..4), then goes to WB.
  - WB: round, saturate and update delay lines. If sec<SECTIONS-1, advance sec and return to MAC; otherwise register Y, sat and valid=1 and return to IDLE.
- Timing: 6 cycles per section. valid rises 6*SECTIONS cycles after the accepting edge (12 for the default). The next sample can be accepted in the cycle valid is high.
- busy=1 in MAC and WB; busy=0 in IDLE.
- en while busy: sample dropped, overrun pulses, and the computation is unaffected.
- Coefficient writes:
  - Accepted only when busy=0; writes while busy are dropped, so coefficients are stable within a sample.
  - A write in the same cycle as sample accept is applied and used for that sample.
  - cfg_sec >= SECTIONS: write ignored.
- Simultaneous clear_state and en in IDLE: the clear is applied first and the sample is processed with zeroed state.
- Reset, including mid-computation:
  - FSM goes to IDLE; all delay lines, Y, valid, sat, overrun and busy go to 0.
  - Every section is loaded with a0=2^FRAC, a1=a2=b1=b2=0, giving identity passthrough.
  - The in-flight sample is discarded with no valid.
- sat is sticky across the sections of one sample and cleared at each accept.

Test Plan:
- Reset passthrough: after rst, en with X=1000 -> exactly 12 cycles later valid=1, Y=1000, sat=0. Repeat with X=-32768 -> Y=-32768.
- FIR averaging: section 0 set to a0=a1=a2=4096, section 1 passthrough; impulse X=4000 then 0,0,0 -> Y=1000,1000,1000,0.
- Feedback decay: section 0 set to a0=16384, b1=-8192; impulse X=1000 then zeros -> Y=1000,500,250,125,63 (rounding check on 62.5).
- Saturation: a0=32767 in both sections, X=30000 -> Y=32767, sat=1. X=-30000 -> Y=-32768, sat=1. Feedback state holds the saturated value.
- Handshake: en pulsed at cycle 3 after an accept -> overrun pulse, sample ignored, next valid at cycle 12 with the original result. A cfg write during busy is dropped; read-back is observed via passthrough output.
- Reset mid-operation: assert rst at cycle 7 of a sample -> no valid, busy=0 next cycle, coefficients back to passthrough. clear_state in IDLE after an impulse -> following zero input gives Y=0.
